// File: rtl/bcd_to_bin_if.sv
// rtl/bcd_to_bin_if.sv - digit request / binary result bundle for bcd_to_bin
interface bcd_to_bin_if;
   logic        start;
   logic [3:0]  one;
   logic [3:0]  ten;
   logic [3:0]  hundred;
   logic [3:0]  thousand;
   logic [3:0]  tenThousand;
   logic [3:0]  hundredThousand;
   logic [3:0]  mil;
   logic [3:0]  tenMil;
   logic        busy;
   logic        done;
   logic [26:0] number;
   logic        err;

   modport master (
      output start, one, ten, hundred, thousand,
             tenThousand, hundredThousand, mil, tenMil,
      input  busy, done, number, err
   );

   modport slave (
      input  start, one, ten, hundred, thousand,
             tenThousand, hundredThousand, mil, tenMil,
      output busy, done, number, err
   );
endinterface

// File: rtl/bcd_to_bin.sv
// rtl/bcd_to_bin.sv - 8-digit BCD to 27-bit binary, reverse double dabble
// Optional invalid-digit checking: define BCD2BIN_DIGIT_CHECK_EN.
module bcd_to_bin (
   input logic         clk,
   input logic         rst,
   bcd_to_bin_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [58:0] work_q, work_d;
   logic [26:0] number_q, number_d;
   logic        done_q, done_d;
   logic        busy_q, busy_d;
   logic [58:0] shifted;
   logic [58:0] corrected;
   logic [31:0] cap_bcd;

   assign cap_bcd = {bus.tenMil, bus.mil, bus.hundredThousand, bus.tenThousand,
                     bus.thousand, bus.hundred, bus.ten, bus.one};

`ifdef BCD2BIN_DIGIT_CHECK_EN
   logic invalid_q, invalid_d;
   logic err_q, err_d;
   logic cap_bad;

   always_comb begin
      cap_bad = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (cap_bcd[4*i +: 4] > 4'd9) cap_bad = 1'b1;
      end
   end
`endif

   // Shift the whole {bcd, bin} word right, then pull each BCD nibble back by 3 if >= 8.
   always_comb begin
      shifted   = {1'b0, work_q[58:1]};
      corrected = shifted;
      for (int i = 0; i < 8; i++) begin
         if (shifted[27 + 4*i +: 4] >= 4'd8) begin
            corrected[27 + 4*i +: 4] = shifted[27 + 4*i +: 4] - 4'd3;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      work_d   = work_q;
      number_d = number_q;
      done_d   = 1'b0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
      invalid_d = invalid_q;
      err_d     = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               work_d  = {cap_bcd, 27'd0};
               cnt_d   = 5'd0;
               state_d = SHIFT;
`ifdef BCD2BIN_DIGIT_CHECK_EN
               invalid_d = cap_bad;
`endif
            end
         end
         SHIFT: begin
            work_d = corrected;
            cnt_d  = cnt_q + 5'd1;
            if (cnt_q == 5'd26) state_d = DONE;
         end
         DONE: begin
            done_d   = 1'b1;
            state_d  = IDLE;
`ifdef BCD2BIN_DIGIT_CHECK_EN
            err_d    = invalid_q;
            number_d = invalid_q ? 27'd0 : work_q[26:0];
`else
            number_d = work_q[26:0];
`endif
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= 5'd0;
         work_q   <= 59'd0;
         number_q <= 27'd0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         work_q   <= work_d;
         number_q <= number_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
      end
   end

`ifdef BCD2BIN_DIGIT_CHECK_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         invalid_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         invalid_q <= invalid_d;
         err_q     <= err_d;
      end
   end

   assign bus.err = err_q;
`else
   assign bus.err = 1'b0;
`endif

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.number = number_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// tb/tb_bcd_to_bin.sv - directed-vector bench for bcd_to_bin
module tb_bcd_to_bin;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   bcd_to_bin_if bus ();

   bcd_to_bin dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_digits(input logic [31:0] d);
      bus.tenMil          = d[31:28];
      bus.mil             = d[27:24];
      bus.hundredThousand = d[23:20];
      bus.tenThousand     = d[19:16];
      bus.thousand        = d[15:12];
      bus.hundred         = d[11:8];
      bus.ten             = d[7:4];
      bus.one             = d[3:0];
   endtask

   // Leaves time at #1 after the accepting edge E0.
   task automatic pulse_start(input logic [31:0] d);
      @(negedge clk);
      set_digits(d);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   // lat = index k of edge Ek after which done is first seen, or -1 on timeout.
   task automatic wait_done(output int lat);
      lat = -1;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk);
         #1;
         if (bus.done === 1'b1) begin
            lat = c;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.start = 1'b0;
      set_digits(32'h0);
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      checks++;
      if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
      checks++;
      if (bus.number !== 27'd0) begin errors++; $display("FAIL reset_number: got %h want 0", bus.number); end
      checks++;
      if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.err); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_convert(input string name, input logic [31:0] d, input logic [26:0] exp);
      int lat;
      pulse_start(d);
      checks++;
      if (bus.busy !== 1'b1) begin errors++; $display("FAIL %s_busy_after_accept: got %b want 1", name, bus.busy); end
      wait_done(lat);
      checks++;
      if (lat !== 28) begin errors++; $display("FAIL %s_latency: got %0d want 28", name, lat); end
      checks++;
      if (bus.number !== exp) begin errors++; $display("FAIL %s_number: got %h want %h", name, bus.number, exp); end
      checks++;
      if (bus.err !== 1'b0) begin errors++; $display("FAIL %s_err: got %b want 0", name, bus.err); end
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL %s_busy_at_done: got %b want 0", name, bus.busy); end
      @(posedge clk);
      #1;
      checks++;
      if (bus.done !== 1'b0) begin errors++; $display("FAIL %s_done_width: got %b want 0", name, bus.done); end
   endtask

   task automatic test_ignore_start();
      int lat;
      int busy_drop;
      lat = -1;
      busy_drop = 0;
      pulse_start(32'h00000321);
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk);
         #1;
         if (c < 28 && bus.busy !== 1'b1) busy_drop++;
         if (bus.done === 1'b1) begin
            lat = c;
            break;
         end
         if (c == 4) begin
            set_digits(32'h00000999);
            bus.start = 1'b1;
         end
         if (c == 5) bus.start = 1'b0;
      end
      checks++;
      if (busy_drop !== 0) begin errors++; $display("FAIL ignore_busy: got %0d low cycles want 0", busy_drop); end
      checks++;
      if (lat !== 28) begin errors++; $display("FAIL ignore_latency: got %0d want 28", lat); end
      checks++;
      if (bus.number !== 27'd321) begin errors++; $display("FAIL ignore_number: got %0d want 321", bus.number); end
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL ignore_no_second: busy got %b want 0", bus.busy); end
   endtask

   task automatic test_reset_abort();
      int seen;
      seen = 0;
      pulse_start(32'h12345678);
      for (int c = 1; c <= 9; c++) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
      checks++;
      if (bus.number !== 27'd0) begin errors++; $display("FAIL abort_number: got %h want 0", bus.number); end
      for (int c = 0; c < 40; c++) begin
         @(posedge clk);
         #1;
         if (bus.done === 1'b1) seen++;
      end
      checks++;
      if (seen !== 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses want 0", seen); end
      test_convert("after_abort", 32'h00000042, 27'd42);
   endtask

`ifdef BCD2BIN_DIGIT_CHECK_EN
   task automatic test_digit_check();
      int lat;
      pulse_start(32'h0000000A);
      wait_done(lat);
      checks++;
      if (lat !== 28) begin errors++; $display("FAIL check_latency: got %0d want 28", lat); end
      checks++;
      if (bus.err !== 1'b1) begin errors++; $display("FAIL check_err: got %b want 1", bus.err); end
      checks++;
      if (bus.number !== 27'd0) begin errors++; $display("FAIL check_number: got %h want 0", bus.number); end
      test_convert("check_recover", 32'h00000007, 27'd7);
   endtask
`endif

   task automatic test_back_to_back();
      int pulses;
      int next_exp;
      int bad_pos;
      int bad_num;
      pulses = 0;
      next_exp = 28;
      bad_pos = 0;
      bad_num = 0;
      @(negedge clk);
      set_digits(32'h00001000);
      bus.start = 1'b1;
      // Edge 0 below is the first accepting edge.
      @(posedge clk);
      for (int c = 1; c <= 100; c++) begin
         @(posedge clk);
         #1;
         if (bus.done === 1'b1) begin
            pulses++;
            if (c !== next_exp) bad_pos++;
            if (bus.number !== 27'd1000) bad_num++;
            next_exp = c + 29;
         end
      end
      bus.start = 1'b0;
      checks++;
      if (pulses !== 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", pulses); end
      checks++;
      if (bad_pos !== 0) begin errors++; $display("FAIL b2b_spacing: got %0d misplaced want 0", bad_pos); end
      checks++;
      if (bad_num !== 0) begin errors++; $display("FAIL b2b_number: got %0d wrong want 0", bad_num); end
      repeat (40) @(posedge clk);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus.start = 1'b0;
      set_digits(32'h0);
      test_reset();
      test_convert("seq", 32'h12345678, 27'h0BC614E);
      test_convert("nines", 32'h99999999, 27'h5F5E0FF);
      test_convert("zeros", 32'h00000000, 27'd0);
      test_convert("mixed", 32'h80000001, 27'd80000001);
      test_ignore_start();
      test_convert("reload", 32'h00500000, 27'd500000);
      test_reset_abort();
`ifdef BCD2BIN_DIGIT_CHECK_EN
      test_digit_check();
`endif
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
